// File: rtl/seven_seg_pkg.sv
// Shared definitions for seven-segment display blocks: segment type,
// all-off constants, scan FSM state encoding and digit-enable helper.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  // Active-low one-hot enable for the selected digit.
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to active-low {a,b,c,d,e,f,g} segment decode.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a blanking gap before
// each digit slot and a one-deep load buffer committed at frame boundaries.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic [3:0]  blank_mask,
  output seg_t        seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [0:0]       state_reg, state_next;
  logic [1:0]       idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]      active_reg, active_next;
  logic [15:0]      pending_reg, pending_next;
  logic             pending_full_reg, pending_full_next;
  logic             frame_done_reg, frame_done_next;

  logic             boundary;
  logic             commit;
  logic             capture;
  logic [3:0]       digit_hex;
  seg_t             dec_seg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    boundary   = 1'b0;
    if (!enable) begin
      state_next = ST_BLANK;
      idx_next   = 2'd0;
      cnt_next   = '0;
    end else if (state_reg == ST_BLANK) begin
      if (cnt_reg == BLANK_LAST) begin
        state_next = ST_DRIVE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else begin
      if (cnt_reg == DRIVE_LAST) begin
        state_next = ST_BLANK;
        cnt_next   = '0;
        idx_next   = idx_reg + 2'd1;
        boundary   = (idx_reg == 2'd3);
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Commit and capture are mutually exclusive: capture needs the buffer empty,
  // commit needs it full. While disabled a pending value commits right away.
  always_comb begin
    commit            = pending_full_reg && (!enable || boundary);
    capture           = load_valid && !pending_full_reg;
    active_next       = commit  ? pending_reg : active_reg;
    pending_next      = capture ? load_data   : pending_reg;
    pending_full_next = capture ? 1'b1 : (commit ? 1'b0 : pending_full_reg);
    frame_done_next   = boundary;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_BLANK;
      idx_reg          <= 2'd0;
      cnt_reg          <= '0;
      active_reg       <= 16'h0000;
      pending_reg      <= 16'h0000;
      pending_full_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      cnt_reg          <= cnt_next;
      active_reg       <= active_next;
      pending_reg      <= pending_next;
      pending_full_reg <= pending_full_next;
      frame_done_reg   <= frame_done_next;
    end
  end

  assign digit_hex = active_reg[{idx_reg, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex (digit_hex),
    .seg (dec_seg)
  );

  // Outputs come straight from registered state; blank_mask acts immediately.
  always_comb begin
    seg = SEG_OFF;
    an  = AN_OFF;
    if (state_reg == ST_DRIVE && !blank_mask[idx_reg]) begin
      seg = dec_seg;
      an  = an_select(idx_reg);
    end
  end

  assign load_ready = ~pending_full_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a frame-position reference model
// predicts each cycle's outputs; a negedge monitor compares against the DUT.
module tb_seven_seg_scan_ctrl;

  localparam int DC    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
    logic       rdy;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  blank_mask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  string       phase = "reset";
  logic [6:0]  seg_tab [16];

  int          m_pos;
  logic [15:0] m_active;
  logic [15:0] m_pend;
  logic        m_full;
  logic        m_fd;

  seven_seg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .blank_mask (blank_mask),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
    seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
    seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
    seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
  end

  task automatic m_reset();
    m_pos    = 0;
    m_active = 16'h0000;
    m_pend   = 16'h0000;
    m_full   = 1'b0;
    m_fd     = 1'b0;
  endtask

  // Outputs follow from the position within the 24-cycle frame.
  function automatic exp_t m_expect();
    exp_t        e;
    int          digit;
    logic [15:0] shifted;
    logic [3:0]  nib;
    digit   = m_pos / SLOT;
    shifted = m_active >> (4 * digit);
    nib     = shifted[3:0];
    e.seg   = 7'b1111111;
    e.an    = 4'b1111;
    if ((m_pos % SLOT) >= BC && !blank_mask[digit]) begin
      e.seg = seg_tab[nib];
      e.an  = 4'b1111 & ~(4'b0001 << digit);
    end
    e.fd  = m_fd;
    e.rdy = !m_full;
    return e;
  endfunction

  initial begin : model
    logic        s_rst, s_en, s_v, bnd, cm, cp;
    logic [15:0] s_d;
    m_reset();
    forever begin
      @(posedge clk);
      s_rst = reset; s_en = enable; s_v = load_valid; s_d = load_data;
      if (s_rst) begin
        m_reset();
      end else begin
        bnd = s_en && (m_pos == FRAME - 1);
        cm  = m_full && (!s_en || bnd);
        cp  = s_v && !m_full;
        if (cm) begin m_active = m_pend; m_full = 1'b0; end
        if (cp) begin m_pend = s_d; m_full = 1'b1; end
        m_fd  = bnd;
        m_pos = s_en ? (m_pos + 1) % FRAME : 0;
      end
      #2;
      if (reset) m_reset();
      q.push_back(m_expect());
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({seg, an, frame_done, load_ready} !== e) begin
          n_bad++;
          $display("FAIL outputs [%s] t=%0t got seg=%b an=%b fd=%b rdy=%b expected seg=%b an=%b fd=%b rdy=%b",
                   phase, $time, seg, an, frame_done, load_ready, e.seg, e.an, e.fd, e.rdy);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_an(input logic [3:0] target, input logic any_drive, input string nm);
    bit found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      if (any_drive ? (an != 4'b1111) : (an == target)) found = 1;
      else step();
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout got an=%b required an=%b", nm, an, target);
    end
  endtask

  initial begin : driver
    int en_off;
    reset = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = 16'h0000; blank_mask = 4'b0000;
    repeat (3) step();

    phase = "idle_scan";
    reset = 1'b0; enable = 1'b1;
    repeat (61) step();

    phase = "load_8f21";
    load_valid = 1'b1; load_data = 16'h8F21;
    step();
    load_data = 16'h1234;
    repeat (30) step();
    load_valid = 1'b0;
    repeat (50) step();

    phase = "mask_0100";
    blank_mask = 4'b0100;
    repeat (30) step();
    blank_mask = 4'b0000;

    phase = "disable_mid_digit2";
    wait_an(4'b1011, 1'b0, "wait_digit2");
    load_valid = 1'b1; load_data = 16'hABCD;
    step();
    load_valid = 1'b0; enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (30) step();

    phase = "reset_mid_drive";
    wait_an(4'b0000, 1'b1, "wait_drive");
    load_valid = 1'b1; load_data = 16'h5A5A;
    step();
    load_valid = 1'b0; reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (30) step();

    phase = "random";
    en_off = 0;
    for (int c = 0; c < 2500; c++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom);
      if ($urandom_range(0, 9) == 0) blank_mask = 4'($urandom);
      if (en_off > 0) begin
        en_off--;
        enable = (en_off == 0);
      end else if ($urandom_range(0, 39) == 0) begin
        en_off = $urandom_range(1, 8);
        enable = 1'b0;
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; enable = 1'b1; load_valid = 1'b0;
    repeat (4) step();

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() > 1) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d left required at most 1", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter DIGIT_CYCLES, default 50000: clock cycles each digit is driven per scan slot; legal range is 1 or more.
REQ-002 Parameter BLANK_CYCLES, default 16: all-off clock cycles before each digit slot (anti-ghosting); legal range is 1 or more.
REQ-003 The block has one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: scanning enabled when high.
REQ-007 Port load_valid, input, 1 bit: a new 16-bit display value is offered.
REQ-008 Port load_data, input, 16 bits: four hex digits, digit k in bits [4k+3:4k].
REQ-009 Port load_ready, output, 1 bit: the block can accept a value.
REQ-010 Port blank_mask, input, 4 bits: when bit k is 1, digit k stays dark during its slot.
REQ-011 Port seg, output, 7 bits: {a,b,c,d,e,f,g} on the shared segment bus, active-low.
REQ-012 Port an, output, 4 bits: digit enables, active-low, an[k] selects digit k.
REQ-013 Port frame_done, output, 1 bit: one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-014 The FSM SHALL have two states: BLANK lasts exactly BLANK_CYCLES cycles, then goes to DRIVE; DRIVE lasts exactly DIGIT_CYCLES cycles, then goes to BLANK with the digit index advanced.
REQ-015 The 2-bit digit index SHALL advance 0,1,2,3 and wrap from 3 to 0; one frame is 4*(BLANK_CYCLES+DIGIT_CYCLES) cycles.
REQ-016 In BLANK, outputs SHALL be an=1111 and seg=1111111.
REQ-017 In DRIVE, an SHALL have bit idx low and all others high, and seg SHALL be the decode of active[4*idx+3:4*idx]; if blank_mask[idx]=1, an=1111 and seg=1111111 instead.
REQ-018 seg and an SHALL be derived from registered state with no extra pipeline stage; they change in the same cycle as the state/index registers.
REQ-019 Decode (seg, active-low) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-020 Handshake: load_valid=1 and load_ready=1 on a clock edge SHALL capture load_data into the pending register and set pending_full; load_ready SHALL equal NOT pending_full.
REQ-021 When enable=1, pending SHALL be copied to the active register only on the cycle DRIVE of digit 3 ends (frame boundary), clearing pending_full; the active value never changes mid-frame.
REQ-022 frame_done SHALL pulse high for exactly one cycle on the cycle after each frame boundary, whether or not a commit occurred.
REQ-023 A capture and a frame boundary in the same cycle cannot collide, because ready=0 while pending is full; a capture on a boundary cycle with pending empty SHALL commit at the next boundary.
REQ-024 When enable=0, the FSM SHALL be held in BLANK with idx=0 and the cycle counter=0, outputs SHALL be dark, any pending value SHALL commit on the next edge, and frame_done SHALL stay 0.
REQ-025 When enable rises, the first cycle SHALL be the first BLANK cycle of digit 0.
REQ-026 A blank_mask change SHALL take effect in the same cycle; no register stage is applied to it.

Reset
REQ-027 Asserting reset SHALL immediately set: state=BLANK, idx=0, counter=0, active=0000h, pending=0000h, pending_full=0, load_ready=1, an=1111, seg=1111111, frame_done=0.
REQ-028 Reset asserted mid-frame or mid-handshake SHALL discard any pending value without committing it.
REQ-029 The first edge after reset deassertion with enable=1 SHALL be the first BLANK cycle of digit 0.

Structure
REQ-030 The state encoding, the seg_t 7-bit type, and the all-off constants (SEG_OFF=1111111, AN_OFF=1111) SHALL live in a shared package, seven_seg_pkg.
REQ-031 The hex-to-segment decode SHALL be one combinational sub-module, hex_to_seg, shared with other display blocks.

Verification (DIGIT_CYCLES=4, BLANK_CYCLES=2, frame=24 cycles)
REQ-032 Reset release, enable=1, no load -> an walks 1110,1101,1011,0111 with 2 dark cycles before each 4-cycle slot; seg=0000001; frame_done pulses every 24 cycles.
REQ-033 Load 8F21h mid-frame -> load_ready drops the next cycle; the display stays 0000h until the boundary; the next frame shows digit0=1001111, digit1=0010010, digit2=0111000, digit3=0000000; ready returns to 1 after the commit.
REQ-034 Second load_valid held while pending is full -> not accepted until ready=1; no data loss, no overwrite.
REQ-035 blank_mask=0100 -> the digit-2 slot shows an=1111 and seg=1111111; other digits are unaffected; frame timing is unchanged.
REQ-036 enable=0 mid-slot of digit 2 with a load pending -> outputs dark and the value committed on the next edge; re-enable -> scan restarts at digit 0 BLANK.
REQ-037 reset pulse mid-DRIVE with a pending value -> outputs dark at once, active=0000h, and the display after release shows zeros.
